// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding, default bus widths
// and the response record returned to the initiator.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_requester_timeout.sv
// ACCESS wait-state counter; o_expire flags the wait cycle that hits LIMIT.
// Only instantiated when APB_REQUESTER_TIMEOUT_EN is defined.
module apb_requester_timeout #(
  parameter int LIMIT = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] r_count;

  // The wait cycle that would bring the count to LIMIT is the abort cycle.
  assign o_expire = i_enable && (r_count == CNT_W'(LIMIT - 1));

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/apb_requester.sv
// APB3 requester: one valid/ready command -> one SETUP/ACCESS transfer -> one
// buffered response. Define APB_REQUESTER_TIMEOUT_EN to bound ACCESS wait states.
module apb_requester
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_e        r_state;
  apb_state_e        w_next_state;
  logic              w_cmd_ready;
  logic              w_accept;
  logic              w_complete;
  logic              w_abort;
  logic              w_expire;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  // A pending response blocks new commands, so the one-entry buffer never overflows.
  assign w_cmd_ready = !preset && (r_state == IDLE) && !r_rsp_valid;

`ifdef APB_REQUESTER_TIMEOUT_EN
  apb_requester_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .pclk     (pclk),
    .preset   (preset),
    .i_clear  (w_complete || w_abort),
    .i_enable ((r_state == ACCESS) && !pready),
    .o_expire (w_expire)
  );
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES < 1);
  assign w_expire     = 1'b0;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; any path that
    // skipped an assignment would otherwise infer a latch.
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_complete   = 1'b0;
    w_abort      = 1'b0;
    psel         = 1'b0;
    penable      = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid && w_cmd_ready) begin
          w_accept     = 1'b1;
          w_next_state = SETUP;
        end
      end
      SETUP: begin
        psel         = 1'b1;
        w_next_state = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          w_complete   = 1'b1;
          w_next_state = IDLE;
        end else if (w_expire) begin
          w_abort      = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Address/data/direction only change on command acceptance, so they hold in IDLE.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pwrite <= cmd_write;
        r_paddr  <= cmd_addr;
        r_pwdata <= cmd_wdata;
      end
      if (w_complete) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= r_pwrite ? '0 : prdata;
        r_rsp_err   <= pslverr;
      end else if (w_abort) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= '0;
        r_rsp_err   <= 1'b1;
      end else if (r_rsp_valid && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
